// File: rtl/vector_reduce_if.sv
// Stream bus between the input buffer, vector_reduce and the next filter/packing stage.
// The master drives vectors and configuration; the slave returns reduced vectors.
interface vector_reduce_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
);
  logic                           tracing;
  logic                           valid_in;
  logic                           eof_in;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_in;
  logic [7:0]                     configId;
  logic [7:0]                     configData;
  logic                           valid_out;
  logic                           eof_out;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_out;

  modport master (
    output tracing, valid_in, eof_in, vector_in, configId, configData,
    input  valid_out, eof_out, vector_out
  );

  modport slave (
    input  tracing, valid_in, eof_in, vector_in, configId, configData,
    output valid_out, eof_out, vector_out
  );
endinterface

// File: rtl/vector_reduce.sv
// Vector reduction stage: passthrough, per-vector adder-tree sum, or element-wise
// frame accumulation; fixed latency of $clog2(N)+1 cycles in every mode.
module vector_reduce #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int REDUCE_ID  = 3
) (
  input  logic           clk,
  input  logic           rst,
  vector_reduce_if.slave io_bus
);

  localparam int         LOG2N  = $clog2(N);
  localparam logic [7:0] CFG_ID = 8'(REDUCE_ID);

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_SUM  = 2'd1,
    MODE_ACC  = 2'd2
  } mode_e;

  function automatic logic signed [DATA_WIDTH-1:0] wrap_add(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return a + b;
  endfunction

  function automatic mode_e norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_PASS : mode_e'(m);
  endfunction

  mode_e                         r_mode;
  logic signed [DATA_WIDTH-1:0]  r_acc     [N];
  logic signed [DATA_WIDTH-1:0]  r_dat_p   [LOG2N+1][N];
  logic [LOG2N:0]                r_vld_p;
  logic [LOG2N:0]                r_eof_p;
  logic [LOG2N:0]                r_sum_p;

  logic                          w_cfg_wr;
  logic                          w_in_vld;
  mode_e                         w_mode;
  logic signed [DATA_WIDTH-1:0]  w_acc_base [N];
  logic signed [DATA_WIDTH-1:0]  w_acc_sum  [N];
  logic signed [DATA_WIDTH-1:0]  w_tree_nxt [1:LOG2N][N];
  logic                          w_unused;

  assign w_unused = ^{io_bus.configData[7:2], r_sum_p[LOG2N]};

  // A config write in the same cycle as a vector wins: new mode, empty accumulator.
  always_comb begin
    w_cfg_wr = (io_bus.configId == CFG_ID);
    w_in_vld = io_bus.tracing & io_bus.valid_in;
    w_mode   = w_cfg_wr ? norm_mode(io_bus.configData[1:0]) : r_mode;
    for (int i = 0; i < N; i++) begin
      w_acc_base[i] = w_cfg_wr ? '0 : r_acc[i];
      w_acc_sum[i]  = wrap_add(w_acc_base[i], io_bus.vector_in[i]);
    end
  end

  // ---- stage 0: capture input, mode tag and accumulator update ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode  <= MODE_PASS;
      r_vld_p <= '0;
      r_eof_p <= '0;
      r_sum_p <= '0;
      for (int i = 0; i < N; i++) r_acc[i] <= '0;
    end else begin
      r_mode <= w_mode;
      if (w_in_vld && (w_mode == MODE_ACC)) begin
        for (int i = 0; i < N; i++) r_acc[i] <= io_bus.eof_in ? '0 : w_acc_sum[i];
      end else if (w_cfg_wr) begin
        for (int i = 0; i < N; i++) r_acc[i] <= '0;
      end
      r_vld_p[0]       <= w_in_vld && ((w_mode != MODE_ACC) || io_bus.eof_in);
      r_eof_p[0]       <= w_in_vld && io_bus.eof_in;
      r_sum_p[0]       <= (w_mode == MODE_SUM);
      // ---- stages 1..LOG2N: control bits follow the tree levels ----
      r_vld_p[LOG2N:1] <= r_vld_p[LOG2N-1:0];
      r_eof_p[LOG2N:1] <= r_eof_p[LOG2N-1:0];
      r_sum_p[LOG2N:1] <= r_sum_p[LOG2N-1:0];
    end
  end

  // Tree level s halves the live element count; non-sum vectors ride through unchanged.
  always_comb begin
    for (int s = 1; s <= LOG2N; s++) begin
      for (int j = 0; j < N; j++) begin
        w_tree_nxt[s][j] = r_sum_p[s-1] ? '0 : r_dat_p[s-1][j];
      end
      for (int j = 0; j < N / 2; j++) begin
        if (r_sum_p[s-1] && (j < (N >> s))) begin
          w_tree_nxt[s][j] = wrap_add(r_dat_p[s-1][2*j], r_dat_p[s-1][2*j+1]);
        end
      end
    end
  end

  // ---- data path registers: stage 0 and tree levels, no reset needed ----
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      r_dat_p[0][i] <= (w_mode == MODE_ACC) ? w_acc_sum[i] : io_bus.vector_in[i];
    end
    for (int s = 1; s <= LOG2N; s++) begin
      for (int i = 0; i < N; i++) r_dat_p[s][i] <= w_tree_nxt[s][i];
    end
  end

  // Output is masked by valid so reset clears it without resetting the data path.
  always_comb begin
    io_bus.valid_out = r_vld_p[LOG2N];
    io_bus.eof_out   = r_vld_p[LOG2N] & r_eof_p[LOG2N];
    for (int i = 0; i < N; i++) begin
      io_bus.vector_out[i] = r_vld_p[LOG2N] ? r_dat_p[LOG2N][i] : '0;
    end
  end

endmodule

// File: doc/vector_reduce.md
# vector_reduce

Reduction stage placed directly downstream of the input buffer. It consumes one N-element vector per cycle, tagged with valid and end-of-frame (EOF), and emits reduced vectors to the next filter/packing stage after a fixed pipeline latency. It has three runtime-selectable modes:
- **Passthrough.**
- **Per-vector sum.** Pipelined adder tree.
- **Frame accumulate.** Element-wise sum across all vectors up to EOF.

## Interface
Parameters:
- `N`, 8: elements per vector. Must be a power of two, ≥2.
- `DATA_WIDTH`, 32: element width in bits. Values are two's complement.
- `REDUCE_ID`, 3: `configId` value addressed to this block.

Ports. Single clock `clk`. Reset `rst` is asynchronous and active-high.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `tracing` in 1: when 0, `valid_in` is treated as 0.
- `valid_in` in 1: `vector_in` holds data this cycle.
- `eof_in` in 1: last vector of the frame. Sampled only when `valid_in`=1.
- `vector_in` in `DATA_WIDTH` × [N-1:0]: input vector.
- `configId` in 8: configuration target.
- `configData` in 8: configuration payload. Bits [1:0] are the mode.
- `valid_out` out 1: `vector_out` is valid.
- `eof_out` out 1: output vector closes a frame.
- `vector_out` out `DATA_WIDTH` × [N-1:0]: result vector.

## Operation
- **Mode register.**
  - Reset value 0.
  - Written when `configId`==`REDUCE_ID`: `mode <= configData[1:0]`.
  - Value 3 is treated as 0.
  - A write also clears the frame accumulator.
  - Mode is captured at the input stage together with each vector and travels down the pipeline with it. In-flight vectors finish in the mode they entered with.
- **Mode 0, passthrough.**
  - `vector_out` equals `vector_in`, delayed by L.
  - `eof_out` equals `eof_in`, delayed by L.
- **Mode 1, per-vector sum.**
  - `vector_out[0]` = sum of all N elements, modulo 2^`DATA_WIDTH` (wrap, no saturation).
  - `vector_out[N-1:1]` = 0.
  - `eof_out` equals `eof_in`, delayed by L.
- **Mode 2, frame accumulate.**
  - `acc[i] += vector_in[i]` on each valid input, wrap modulo 2^`DATA_WIDTH`.
  - Output is produced only for the vector carrying EOF: `vector_out` = accumulator including that vector, with `valid_out`=1 and `eof_out`=1.
  - Non-EOF vectors produce `valid_out`=0.
  - The accumulator resets to 0 on the same edge that absorbs the EOF vector, so the next cycle starts a new frame. Back-to-back single-vector frames are legal.
- **`tracing`=0.**
  - Inputs are ignored.
  - The accumulator holds its value.
  - Vectors already in flight still drain.
- **No backpressure.** Throughput is one vector per cycle in every mode.
- **Simultaneous config write and valid input.** The config write wins: the accumulator is cleared and the new mode applies to that same input vector.

## Timing
- Latency L = $clog2(N)+1 cycles, identical in all modes. Passthrough is padded to match.
  - A vector sampled at edge t appears on edge t+L.
  - Defaults: L=4.
- Pipeline structure:
  - Stage 0 registers the input, mode, valid and eof.
  - Stages 1..$clog2(N) are the adder-tree levels.
  - The mode-2 accumulator is updated at stage 0. Its result rides the same stages unchanged.
- Per-stage valid bits travel with the data.
- Reset values:
  - `valid_out`=0, `eof_out`=0, `vector_out`=all 0.
  - Mode 0, accumulator 0, all pipeline valid bits 0.
- Reset mid-operation: in-flight data is discarded immediately and asynchronously. No output follows for vectors accepted before reset.
- `eof_in` with `valid_in`=0 has no effect.

## Test plan
All scenarios use N=8, `DATA_WIDTH`=32, L=4.
- **Reset.** Assert `rst` while vectors are in flight. → Outputs go to 0 immediately. No `valid_out` appears in the following 4 cycles.
- **Mode 0.** Stream vectors k=0..9 with element i = 10k+i, eof on k=9. → Identical vectors emerge 4 cycles later. `eof_out` is high only for k=9. `valid_out` stays continuous.
- **Mode 1 with overflow.** Send elements {1..8}, then all elements = 0x7FFFFFFF. → First output `vector_out[0]`=36. Second output `vector_out[0]`=0xFFFFFFF8. All other elements are 0.
- **Mode 2, frames of lengths 3, 1, 2 back-to-back.** All elements are 1, 2, 3 respectively per frame. → Exactly 3 outputs, all elements 3, 2, 6, each with `eof_out`=1. No output for non-EOF vectors.
- **Mode switch mid-stream.** Switch to mode 1 while mode-0 vectors are in flight, then write mode 2 mid-frame. → In-flight vectors exit unmodified. The accumulator is cleared. The next EOF output sums only the vectors received after the write.
- **`tracing` toggle.** Drop `tracing` for 2 cycles during a mode-2 frame. → The vectors in those cycles are excluded from the sum. The accumulator is preserved across the gap.
